// File: rtl/ingr_tuser_pkt_filter.sv
// rtl/ingr_tuser_pkt_filter.sv - store-and-forward ingress filter dropping tuser-marked and oversized frames
module ingr_tuser_pkt_filter #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int BUFFER_DEPTH   = 512,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                              aclk,
  input  logic                                              aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]                         axis_in_tdata,
  input  logic                                              axis_in_tuser,
  input  logic [AXIS_ID_WIDTH:0]                            axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]                       axis_in_tkeep,
  input  logic                                              axis_in_tlast,
  input  logic                                              axis_in_tvalid,
  output logic                                              axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]                         axis_out_tdata,
  output logic [((AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH)-1:0] axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]                       axis_out_tkeep,
  output logic                                              axis_out_tlast,
  output logic                                              axis_out_tvalid,
  input  logic                                              axis_out_tready,
  output logic [CNT_WIDTH-1:0]                              drop_err_count,
  output logic [CNT_WIDTH-1:0]                              drop_ovf_count
);
  localparam int KW  = AXIS_BUS_WIDTH / 8;
  localparam int IDW = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH;
  localparam int AW  = $clog2(BUFFER_DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = AXIS_BUS_WIDTH + KW + 1 + IDW;
  localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);

  typedef enum logic {S_ACCEPT, S_DROP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic                 ready_en_q;
  logic                 full, avail, in_fire, mem_we;
  logic                 rd_en, s1_adv, rd_valid_q, out_valid_q;
  logic [EW-1:0]        mem [BUFFER_DEPTH];
  logic [EW-1:0]        ram_q, out_data_q;
  logic                 unused_tdest_msb;

  assign unused_tdest_msb = axis_in_tdest[AXIS_ID_WIDTH];

  assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign avail   = rd_ptr_q != commit_ptr_q;
  // ready_en_q keeps tready low while reset is held and for the release cycle
  assign axis_in_tready = ready_en_q && ((state_q == S_DROP) || !full);
  assign in_fire = axis_in_tvalid && axis_in_tready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    err_cnt_d    = err_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    mem_we       = 1'b0;
    case (state_q)
      S_ACCEPT: begin
        if (full && (commit_ptr_q == rd_ptr_q)) begin
          state_d  = S_DROP;
          wr_ptr_d = commit_ptr_q;
        end else if (in_fire) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (axis_in_tlast) begin
            if (axis_in_tuser) begin
              wr_ptr_d = commit_ptr_q;
              if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end else begin
              commit_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end
      end
      S_DROP: begin
        if (in_fire && axis_in_tlast) begin
          state_d = S_ACCEPT;
          if (!(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      err_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      err_cnt_q    <= err_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Read side: RAM output register (stage 1) feeding the output register (stage 2)
  assign s1_adv = rd_valid_q && (!out_valid_q || axis_out_tready);
  assign rd_en  = avail && (!rd_valid_q || s1_adv);

  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tdest[IDW-1:0]};
    if (rd_en)  ram_q <= mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr_q   <= rd_ptr_q + PW'(1);
        rd_valid_q <= 1'b1;
      end else if (s1_adv) begin
        rd_valid_q <= 1'b0;
      end
      if (s1_adv) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ram_q;
      end else if (axis_out_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tdest} = out_data_q;
  assign axis_out_tvalid = out_valid_q;
  assign drop_err_count  = err_cnt_q;
  assign drop_ovf_count  = ovf_cnt_q;

endmodule

// File: tb/tb_ingr_tuser_pkt_filter.sv
// tb/tb_ingr_tuser_pkt_filter.sv - scoreboard bench for ingr_tuser_pkt_filter
module tb_ingr_tuser_pkt_filter;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  logic        aclk, aresetn;
  logic [63:0] in_data;
  logic        in_user, in_last, in_valid;
  logic [4:0]  in_dest;
  logic [7:0]  in_keep;
  logic        axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [3:0]  axis_out_tdest;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast, axis_out_tvalid, out_ready;
  logic [31:0] drop_err_count, drop_ovf_count;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  ingr_tuser_pkt_filter #(
    .AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .BUFFER_DEPTH(DEPTH), .CNT_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(in_data), .axis_in_tuser(in_user), .axis_in_tdest(in_dest),
    .axis_in_tkeep(in_keep), .axis_in_tlast(in_last), .axis_in_tvalid(in_valid),
    .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tdest(axis_out_tdest),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(out_ready),
    .drop_err_count(drop_err_count), .drop_ovf_count(drop_ovf_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && axis_out_tvalid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_beat", 64'd1, 64'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_data", axis_out_tdata, e.data);
        chk("out_keep_last_dest", {51'd0, axis_out_tkeep, axis_out_tlast, axis_out_tdest},
            {51'd0, e.keep, e.last, e.dest});
      end
    end
  end

  task automatic set_out_ready(input logic v);
    @(posedge aclk);
    #1 out_ready = v;
    @(negedge aclk);
  endtask

  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u, input logic [4:0] dst);
    int w;
    in_data = d; in_keep = k; in_last = l; in_user = u; in_dest = dst; in_valid = 1'b1;
    w = 0;
    while (!axis_in_tready && w < 200) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 200) chk("in_tready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic send_pkt(input int n, input logic bad, input logic [4:0] dst,
                          input logic [7:0] last_keep, input logic hold);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      beat_t       e;
      d = {$urandom, $urandom};
      l = (i == n - 1);
      k = l ? last_keep : 8'hFF;
      if (!bad) begin
        e.data = d; e.keep = k; e.last = l; e.dest = dst[3:0];
        sb.push_back(e);
      end
      send_beat(d, k, l, bad && l, dst);
    end
    if (bad) exp_err++;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    repeat (4) @(negedge aclk);
    w = 0;
    while ((sb.size() != 0 || axis_out_tvalid) && w < 500) begin
      @(negedge aclk);
      w++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_tready"}, {63'd0, axis_in_tready}, 64'd0);
    chk({tag, "_out_tvalid"}, {63'd0, axis_out_tvalid}, 64'd0);
    chk({tag, "_out_tdata"}, axis_out_tdata, 64'd0);
    chk({tag, "_counts"}, {drop_err_count, drop_ovf_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    aresetn = 1'b0; out_ready = 1'b1;
    in_data = '0; in_user = 0; in_last = 0; in_valid = 0; in_dest = '0; in_keep = '0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    // T1: first beat must appear two cycles after the tlast beat is taken
    send_pkt(3, 1'b0, 5'h13, 8'h0F, 1'b0);
    chk("t1_lat0", {63'd0, axis_out_tvalid}, 64'd0);
    @(negedge aclk);
    chk("t1_lat1", {63'd0, axis_out_tvalid}, 64'd0);
    @(negedge aclk);
    chk("t1_lat2", {63'd0, axis_out_tvalid}, 64'd1);
    wait_drain("t1_drain");

    // T2: bad frame disappears, next good frame passes
    send_pkt(4, 1'b1, 5'h05, 8'hFF, 1'b0);
    wait_drain("t2_bad_drain");
    chk("t2_err_count", 64'(drop_err_count), 64'(exp_err));
    send_pkt(2, 1'b0, 5'h1A, 8'h03, 1'b0);
    wait_drain("t2_good_drain");

    // T3: good, bad, good with tvalid held high throughout
    send_pkt(2, 1'b0, 5'h01, 8'hFF, 1'b1);
    send_pkt(3, 1'b1, 5'h02, 8'hFF, 1'b1);
    send_pkt(2, 1'b0, 5'h0C, 8'h7F, 1'b0);
    wait_drain("t3_drain");
    chk("t3_err_count", 64'(drop_err_count), 64'(exp_err));

    // T4: stalled output, fill with single-beat packets until backpressure
    set_out_ready(1'b0);
    acc = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (!axis_in_tready) break;
      send_pkt(1, 1'b0, 5'(i), 8'hFF, 1'b1);
      acc++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("t4_tready_low", {63'd0, axis_in_tready}, 64'd0);
    chk("t4_accepted_in_range", {63'd0, (acc >= DEPTH) && (acc <= DEPTH + 2)}, 64'd1);
    chk("t4_no_ovf", 64'(drop_ovf_count), 64'd0);
    set_out_ready(1'b1);
    wait_drain("t4_drain");

    // T5: packet longer than the buffer is dropped as overflow
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i >= DEPTH + 1) chk("t5_tail_tready", {63'd0, axis_in_tready}, 64'd1);
      send_beat({$urandom, $urandom}, 8'hFF, (i == DEPTH + 2), 1'b0, 5'h07);
    end
    in_valid = 1'b0;
    wait_drain("t5_drop_drain");
    chk("t5_ovf_count", 64'(drop_ovf_count), 64'd1);
    chk("t5_err_unchanged", 64'(drop_err_count), 64'(exp_err));
    send_pkt(2, 1'b0, 5'h0E, 8'h01, 1'b0);
    wait_drain("t5_next_drain");

    // T6: reset mid-packet clears everything
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 5'h04);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 5'h04);
    aresetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    sb.delete();
    @(negedge aclk);
    send_pkt(3, 1'b0, 5'h19, 8'h3F, 1'b0);
    wait_drain("t6_drain");
    chk("t6_counts_after", {drop_err_count, drop_ovf_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
